// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter: round-robin sharing of one calc datapath among NUM_REQ requesters with in-order result return.
// Ports: clk/rstn (sync active-low); req_valid/req_a/req_b/req_op in, req_stall out (requester side);
// rsp_valid/rsp_c out, rsp_stall in (result side); calc_a/calc_b/calc_op/calc_ivalid out,
// calc_ostall in (calc issue side); calc_c/calc_ovalid in, calc_istall out (calc result side);
// inflight = tag FIFO occupancy; err_unexp_rsp = sticky flag for a calc result with no owner.
module calc_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 2,
    parameter int TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    input  logic [NUM_REQ*OP_W-1:0]       req_op,
    output logic [NUM_REQ-1:0]            req_stall,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_c,
    input  logic [NUM_REQ-1:0]            rsp_stall,
    output logic [DATA_W-1:0]             calc_a,
    output logic [DATA_W-1:0]             calc_b,
    output logic [OP_W-1:0]               calc_op,
    output logic                          calc_ivalid,
    input  logic                          calc_ostall,
    input  logic [DATA_W-1:0]             calc_c,
    input  logic                          calc_ovalid,
    output logic                          calc_istall,
    output logic [$clog2(TAG_DEPTH):0]    inflight,
    output logic                          err_unexp_rsp
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;
    logic [IW-1:0] ptr, win, head;
    logic [IW-1:0] tags [TAG_DEPTH];
    logic [AW-1:0] wr, rd;
    logic found, slot_free, grant, hit, pop;
    // first requesting index at or after the rr pointer, wrapping at NUM_REQ
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win = IW'((int'(ptr) + k) % NUM_REQ);
            end
    end
    // occupancy is checked before any same-cycle pop so a full FIFO never over-issues
    assign slot_free   = !calc_ivalid || !calc_ostall;
    assign grant       = slot_free && (inflight < CW'(TAG_DEPTH)) && found;
    assign req_stall   = grant ? ~(NUM_REQ'(1) << win) : '1;
    assign head        = tags[rd];
    assign hit         = calc_ovalid && (inflight != '0);
    assign rsp_valid   = hit ? (NUM_REQ'(1) << head) : '0;
    assign rsp_c       = calc_c;
    assign calc_istall = hit && rsp_stall[head];
    assign pop         = hit && !rsp_stall[head];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            calc_ivalid   <= 1'b0;
            calc_a        <= '0;
            calc_b        <= '0;
            calc_op       <= '0;
            ptr           <= '0;
            wr            <= '0;
            rd            <= '0;
            inflight      <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (slot_free) begin
                calc_ivalid <= grant;
                if (grant) begin
                    calc_a  <= req_a[win*DATA_W +: DATA_W];
                    calc_b  <= req_b[win*DATA_W +: DATA_W];
                    calc_op <= req_op[win*OP_W +: OP_W];
                end
            end
            if (grant) begin
                wr  <= wr + AW'(1);
                ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
            end
            if (pop)
                rd <= rd + AW'(1);
            inflight <= inflight + CW'(grant) - CW'(pop);
            if (calc_ovalid && inflight == '0)
                err_unexp_rsp <= 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (grant)
            tags[wr] <= win;
endmodule

// File: tb/tb_calc_req_arbiter.sv
// tb_calc_req_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_calc_req_arbiter;
    logic         clk, rstn;
    logic [3:0]   req_valid, req_stall, rsp_valid, rsp_stall;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_op;
    logic [31:0]  rsp_c, calc_a, calc_b, calc_c;
    logic [1:0]   calc_op;
    logic         calc_ivalid, calc_ostall, calc_ovalid, calc_istall, err_unexp_rsp;
    logic [3:0]   inflight;
    int n_cmp = 0;
    int n_err = 0;

    calc_req_arbiter dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_stall(req_stall), .rsp_valid(rsp_valid), .rsp_c(rsp_c),
        .rsp_stall(rsp_stall), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
        .calc_ivalid(calc_ivalid), .calc_ostall(calc_ostall), .calc_c(calc_c),
        .calc_ovalid(calc_ovalid), .calc_istall(calc_istall), .inflight(inflight),
        .err_unexp_rsp(err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        rsp_stall = '0; calc_ostall = 1'b0; calc_c = '0; calc_ovalid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = '0; req_a = '1; req_b = '1; req_op = '1;
        rsp_stall = '0; calc_ostall = 1'b0; calc_c = '0; calc_ovalid = 1'b0;
        tick();
        tick();
        n_cmp++; if (calc_ivalid !== 1'b0) begin n_err++; $display("FAIL reset_ivalid got %b exp 0", calc_ivalid); end
        n_cmp++; if ({calc_a, calc_b, calc_op} !== 66'd0) begin n_err++; $display("FAIL reset_slot got %h/%h/%h exp 0", calc_a, calc_b, calc_op); end
        n_cmp++; if (inflight !== 4'd0) begin n_err++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        n_cmp++; if (err_unexp_rsp !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err_unexp_rsp); end
        n_cmp++; if (req_stall !== 4'b1111) begin n_err++; $display("FAIL reset_req_stall got %b exp 1111", req_stall); end
        n_cmp++; if (rsp_valid !== 4'b0 || calc_istall !== 1'b0) begin n_err++; $display("FAIL reset_rsp got %b/%b exp 0000/0", rsp_valid, calc_istall); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_a[31:0] = 32'd7; req_b[31:0] = 32'd5; req_op[1:0] = 2'd0; req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_stall !== 4'b1110) begin n_err++; $display("FAIL single_grant got %b exp 1110", req_stall); end
        tick();
        req_valid = '0;
        #1;
        n_cmp++; if (calc_ivalid !== 1'b1 || calc_a !== 32'd7 || calc_b !== 32'd5 || calc_op !== 2'd0)
            begin n_err++; $display("FAIL single_issue got v=%b a=%0d b=%0d op=%0d exp v=1 a=7 b=5 op=0", calc_ivalid, calc_a, calc_b, calc_op); end
        n_cmp++; if (inflight !== 4'd1) begin n_err++; $display("FAIL single_inflight1 got %0d exp 1", inflight); end
        tick();
        n_cmp++; if (calc_ivalid !== 1'b0) begin n_err++; $display("FAIL single_idle got %b exp 0", calc_ivalid); end
        calc_ovalid = 1'b1; calc_c = 32'd12;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_c !== 32'd12 || calc_istall !== 1'b0)
            begin n_err++; $display("FAIL single_rsp got %b c=%0d is=%b exp 0001 c=12 is=0", rsp_valid, rsp_c, calc_istall); end
        tick();
        calc_ovalid = 1'b0;
        #1;
        n_cmp++; if (inflight !== 4'd0) begin n_err++; $display("FAIL single_inflight0 got %0d exp 0", inflight); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (req_stall !== ~(4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_grant%0d got %b exp %b", k, req_stall, ~(4'b0001 << (k % 4))); end
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            calc_ovalid = 1'b1; calc_c = 32'(k + 100);
            #1;
            n_cmp++; if (rsp_valid !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_valid, 4'b0001 << (k % 4)); end
            tick();
        end
        calc_ovalid = 1'b0;
        #1;
        n_cmp++; if (inflight !== 4'd0) begin n_err++; $display("FAIL rr_drain got %0d exp 0", inflight); end
    endtask

    task automatic test_tag_full();
        int g = 0;
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!req_stall[0]) g++;
            tick();
        end
        n_cmp++; if (g != 8) begin n_err++; $display("FAIL full_grants got %0d exp 8", g); end
        n_cmp++; if (inflight !== 4'd8) begin n_err++; $display("FAIL full_inflight got %0d exp 8", inflight); end
        calc_ovalid = 1'b1;
        #1;
        n_cmp++; if (req_stall[0] !== 1'b1) begin n_err++; $display("FAIL full_prepop got %b exp 1", req_stall[0]); end
        tick();
        calc_ovalid = 1'b0;
        #1;
        n_cmp++; if (inflight !== 4'd7 || req_stall[0] !== 1'b0) begin n_err++; $display("FAIL full_pop got %0d/%b exp 7/0", inflight, req_stall[0]); end
        tick();
        n_cmp++; if (inflight !== 4'd8) begin n_err++; $display("FAIL full_refill got %0d exp 8", inflight); end
        req_valid = '0;
    endtask

    task automatic test_ostall();
        do_reset();
        req_a[31:0] = 32'd1; req_b[31:0] = 32'd2; req_op[1:0] = 2'd3; req_valid = 4'b0001;
        tick();
        calc_ostall = 1'b1; req_valid = 4'b0011; req_a[31:0] = 32'd9; req_a[63:32] = 32'd20;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_stall !== 4'b1111) begin n_err++; $display("FAIL ostall_stall%0d got %b exp 1111", k, req_stall); end
            tick();
            n_cmp++; if (calc_ivalid !== 1'b1 || calc_a !== 32'd1 || calc_b !== 32'd2 || calc_op !== 2'd3)
                begin n_err++; $display("FAIL ostall_hold%0d got v=%b a=%0d b=%0d op=%0d exp 1/1/2/3", k, calc_ivalid, calc_a, calc_b, calc_op); end
        end
        calc_ostall = 1'b0;
        #1;
        n_cmp++; if (req_stall !== 4'b1101) begin n_err++; $display("FAIL ostall_release got %b exp 1101", req_stall); end
        tick();
        req_valid = '0;
        n_cmp++; if (calc_a !== 32'd20) begin n_err++; $display("FAIL ostall_load got %0d exp 20", calc_a); end
    endtask

    task automatic test_rsp_stall();
        do_reset();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        calc_ovalid = 1'b1; calc_c = 32'd55; rsp_stall = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (calc_istall !== 1'b1 || rsp_valid !== 4'b0100) begin n_err++; $display("FAIL rstall_hold%0d got is=%b rv=%b exp 1/0100", k, calc_istall, rsp_valid); end
            tick();
            n_cmp++; if (inflight !== 4'd1) begin n_err++; $display("FAIL rstall_nopop%0d got %0d exp 1", k, inflight); end
        end
        rsp_stall = 4'b1011;
        #1;
        n_cmp++; if (calc_istall !== 1'b0 || rsp_valid !== 4'b0100) begin n_err++; $display("FAIL rstall_release got is=%b rv=%b exp 0/0100", calc_istall, rsp_valid); end
        tick();
        calc_ovalid = 1'b0; rsp_stall = '0;
        n_cmp++; if (inflight !== 4'd0) begin n_err++; $display("FAIL rstall_pop got %0d exp 0", inflight); end
    endtask

    task automatic test_spurious();
        do_reset();
        calc_ovalid = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0 || calc_istall !== 1'b0) begin n_err++; $display("FAIL spur_rsp got %b/%b exp 0000/0", rsp_valid, calc_istall); end
        tick();
        calc_ovalid = 1'b0;
        tick();
        tick();
        n_cmp++; if (err_unexp_rsp !== 1'b1 || inflight !== 4'd0) begin n_err++; $display("FAIL spur_err got %b/%0d exp 1/0", err_unexp_rsp, inflight); end
        req_valid = 4'b1111;
        tick();
        tick();
        n_cmp++; if (inflight !== 4'd2 || calc_ivalid !== 1'b1) begin n_err++; $display("FAIL spur_traffic got %0d/%b exp 2/1", inflight, calc_ivalid); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (inflight !== 4'd0 || calc_ivalid !== 1'b0 || err_unexp_rsp !== 1'b0)
            begin n_err++; $display("FAIL spur_midreset got %0d/%b/%b exp 0/0/0", inflight, calc_ivalid, err_unexp_rsp); end
        rstn = 1'b1; req_valid = '0;
    endtask

    task automatic test_random();
        int rr = 0;
        int q[$];
        bit m_iv = 0, m_err = 0, free, hit;
        logic [31:0] m_a = '0, m_b = '0;
        logic [1:0] m_op = '0;
        int win;
        logic [3:0] e_stall, e_rv;
        bit e_is;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = $urandom;
                req_op[i*2 +: 2] = 2'($urandom);
            end
            calc_ostall = ($urandom_range(0, 3) == 0);
            calc_ovalid = ($urandom_range(0, 9) < 4);
            calc_c = $urandom;
            rsp_stall = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            #1;
            free = !m_iv || !calc_ostall;
            win = -1;
            if (free && q.size() < 8)
                for (int k = 0; k < 4; k++)
                    if (win < 0 && req_valid[(rr + k) % 4]) win = (rr + k) % 4;
            e_stall = (win < 0) ? 4'b1111 : ~(4'b0001 << win);
            hit = calc_ovalid && q.size() > 0;
            e_rv = hit ? (4'b0001 << q[0]) : 4'b0;
            e_is = hit && rsp_stall[q[0]];
            n_cmp++; if (req_stall !== e_stall) begin n_err++; $display("FAIL rnd_req_stall@%0d got %b exp %b", n, req_stall, e_stall); end
            n_cmp++; if (rsp_valid !== e_rv || calc_istall !== e_is || rsp_c !== calc_c)
                begin n_err++; $display("FAIL rnd_rsp@%0d got rv=%b is=%b exp rv=%b is=%b", n, rsp_valid, calc_istall, e_rv, e_is); end
            n_cmp++; if (calc_ivalid !== m_iv || (m_iv && {calc_a, calc_b, calc_op} !== {m_a, m_b, m_op}))
                begin n_err++; $display("FAIL rnd_slot@%0d got v=%b %h/%h/%h exp v=%b %h/%h/%h", n, calc_ivalid, calc_a, calc_b, calc_op, m_iv, m_a, m_b, m_op); end
            n_cmp++; if (inflight !== 4'(q.size()) || err_unexp_rsp !== m_err)
                begin n_err++; $display("FAIL rnd_state@%0d got inflight=%0d err=%b exp %0d/%b", n, inflight, err_unexp_rsp, q.size(), m_err); end
            @(posedge clk);
            if (calc_ovalid && q.size() == 0) m_err = 1;
            if (free) begin
                m_iv = (win >= 0);
                if (win >= 0) begin
                    m_a = req_a[win*32 +: 32];
                    m_b = req_b[win*32 +: 32];
                    m_op = req_op[win*2 +: 2];
                end
            end
            if (hit && !rsp_stall[q[0]]) void'(q.pop_front());
            if (win >= 0) begin
                q.push_back(win);
                rr = (win + 1) % 4;
            end
            #1;
        end
        req_valid = '0; calc_ovalid = 1'b0; calc_ostall = 1'b0; rsp_stall = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_tag_full();
        test_ostall();
        test_rsp_stall();
        test_spurious();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
